// File: rtl/uart_cmd_loader.sv
// uart_cmd_loader: turns the UART byte stream into instruction-memory and
// block-memory writes plus thread-run updates. Frames are
// header / address / data / checksum, and every finished frame is answered
// with one response byte.
module uart_cmd_loader #(
    parameter int BITWIDTH       = 32,
    parameter int NUM_THREADS    = 3,
    parameter int BMEM_WORDS     = 16,
    parameter int TIMEOUT_CYCLES = 1250000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [NUM_THREADS-1:0]         thread_running,
    output logic [BITWIDTH-1:0]            imem_write_addr,
    output logic [BITWIDTH-1:0]            imem_write_data,
    output logic [NUM_THREADS-1:0]         imem_write_valid,
    output logic [BITWIDTH-1:0]            bmem_write_addr,
    output logic [BMEM_WORDS*BITWIDTH-1:0] bmem_write_data,
    output logic                           bmem_write_valid
);

    localparam int BYTES      = BITWIDTH / 8;
    localparam int TILE_BYTES = BYTES * BMEM_WORDS;
    localparam int CW         = (TILE_BYTES > 1) ? $clog2(TILE_BYTES) : 1;
    localparam int TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [7:0] RESP_PING    = 8'hA5;
    localparam logic [7:0] RESP_ACK     = 8'h06;
    localparam logic [7:0] RESP_BUSY    = 8'h16;
    localparam logic [7:0] RESP_NACK    = 8'h15;
    localparam logic [7:0] RESP_TIMEOUT = 8'h17;

    typedef enum logic [1:0] {
        START,
        ADDR,
        DATA,
        CSUM
    } state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [TW-1:0]             idle_q;
    logic                      is_bmem_q;
    logic [7:0]                csum_q;
    logic [BITWIDTH-1:0]       addr_q;
    logic [TILE_BYTES*8-1:0]   tile_q;
    logic [NUM_THREADS-1:0]    running_q;
    logic [NUM_THREADS-1:0]    imem_we_q;
    logic                      bmem_we_q;
    logic                      tx_valid_q;
    logic [7:0]                tx_data_q;

    logic                      accept_w;
    logic [NUM_THREADS-1:0]    grant_w;
    logic [CW-1:0]             data_last_w;

    // A byte is taken only when no response is waiting for the UART.
    assign accept_w = rx_valid && !tx_valid_q;

    // Lowest idle thread: isolate the lowest clear bit of the run flags.
    assign grant_w = ~running_q & (running_q + NUM_THREADS'(1));

    // A BMEM frame carries a whole tile, an IMEM frame a single word.
    assign data_last_w = is_bmem_q ? CW'(TILE_BYTES - 1) : CW'(BYTES - 1);

    // Frame decoder, checksum, timeout and response register in one FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= START;
            cnt_q      <= '0;
            idle_q     <= '0;
            is_bmem_q  <= 1'b0;
            csum_q     <= '0;
            addr_q     <= '0;
            tile_q     <= '0;
            running_q  <= '0;
            imem_we_q  <= '0;
            bmem_we_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            imem_we_q <= '0;
            bmem_we_q <= 1'b0;

            if (tx_valid_q && tx_ready) begin
                tx_valid_q <= 1'b0;
            end

            if (state_q != START && !accept_w && !tx_valid_q) begin
                if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q    <= START;
                    idle_q     <= '0;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= RESP_TIMEOUT;
                end else begin
                    idle_q <= idle_q + TW'(1);
                end
            end

            if (accept_w) begin
                idle_q <= '0;
                case (state_q)
                    START: begin
                        case (rx_data[7:6])
                            2'b00: begin
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= RESP_PING;
                            end
                            2'b11: begin
                                running_q  <= rx_data[NUM_THREADS-1:0];
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= RESP_ACK;
                            end
                            default: begin
                                state_q   <= ADDR;
                                cnt_q     <= '0;
                                csum_q    <= '0;
                                is_bmem_q <= rx_data[7];
                            end
                        endcase
                    end
                    ADDR: begin
                        for (int k = 0; k < BYTES; k++) begin
                            if (cnt_q == CW'(k)) begin
                                addr_q[8*k +: 8] <= rx_data;
                            end
                        end
                        csum_q <= csum_q ^ rx_data;
                        if (cnt_q == CW'(BYTES - 1)) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    DATA: begin
                        for (int n = 0; n < TILE_BYTES; n++) begin
                            if (cnt_q == CW'(n)) begin
                                tile_q[8*n +: 8] <= rx_data;
                            end
                        end
                        csum_q <= csum_q ^ rx_data;
                        if (cnt_q == data_last_w) begin
                            state_q <= CSUM;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    CSUM: begin
                        state_q    <= START;
                        tx_valid_q <= 1'b1;
                        if (rx_data != csum_q) begin
                            tx_data_q <= RESP_NACK;
                        end else if (is_bmem_q) begin
                            bmem_we_q <= 1'b1;
                            tx_data_q <= RESP_ACK;
                        end else if (grant_w != '0) begin
                            imem_we_q <= grant_w;
                            tx_data_q <= RESP_ACK;
                        end else begin
                            tx_data_q <= RESP_BUSY;
                        end
                    end
                    default: state_q <= START;
                endcase
            end
        end
    end

    assign rx_ready         = ~tx_valid_q;
    assign tx_valid         = tx_valid_q;
    assign tx_data          = tx_data_q;
    assign thread_running   = running_q;
    assign imem_write_addr  = addr_q;
    assign imem_write_data  = tile_q[BITWIDTH-1:0];
    assign imem_write_valid = imem_we_q;
    assign bmem_write_addr  = addr_q;
    assign bmem_write_data  = tile_q;
    assign bmem_write_valid = bmem_we_q;

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed bench for uart_cmd_loader: ping, IMEM thread selection, busy,
// BMEM tile write, checksum error, inter-byte timeout and mid-frame reset.
module tb_uart_cmd_loader;

    localparam int BITWIDTH    = 32;
    localparam int NUM_THREADS = 3;
    localparam int BMEM_WORDS  = 16;
    localparam int TIMEOUT     = 100;

    logic                           clock = 1'b0;
    logic                           reset = 1'b1;
    logic [7:0]                     rxData = '0;
    logic                           rxValid = 1'b0;
    logic                           rxReady;
    logic [7:0]                     txData;
    logic                           txValid;
    logic                           txReady = 1'b0;
    logic [NUM_THREADS-1:0]         threadRunning;
    logic [BITWIDTH-1:0]            imemAddr;
    logic [BITWIDTH-1:0]            imemData;
    logic [NUM_THREADS-1:0]         imemValid;
    logic [BITWIDTH-1:0]            bmemAddr;
    logic [BMEM_WORDS*BITWIDTH-1:0] bmemData;
    logic                           bmemValid;

    int checks = 0;
    int errors = 0;

    uart_cmd_loader #(
        .BITWIDTH(BITWIDTH),
        .NUM_THREADS(NUM_THREADS),
        .BMEM_WORDS(BMEM_WORDS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_data(rxData),
        .rx_valid(rxValid),
        .rx_ready(rxReady),
        .tx_data(txData),
        .tx_valid(txValid),
        .tx_ready(txReady),
        .thread_running(threadRunning),
        .imem_write_addr(imemAddr),
        .imem_write_data(imemData),
        .imem_write_valid(imemValid),
        .bmem_write_addr(bmemAddr),
        .bmem_write_data(bmemData),
        .bmem_write_valid(bmemValid)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    // Hard stop in case a wait outside the bounded loops ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed hang, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one byte and return 1 ns after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] value);
        logic accepted;
        accepted = 1'b0;
        rxData  = value;
        rxValid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            accepted = (rxReady === 1'b1);
            tick();
        end
        rxValid = 1'b0;
        if (!accepted) begin
            checkOutput("rx_accept", {63'd0, accepted}, 64'd1);
        end
    endtask

    // Check the pending response, then hand it to the UART.
    task automatic takeResponse(input string tag, input logic [7:0] code);
        checkOutput({tag, "_txvalid"}, {63'd0, txValid}, 64'd1);
        checkOutput({tag, "_txdata"}, {56'd0, txData}, {56'd0, code});
        txReady = 1'b1;
        tick();
        txReady = 1'b0;
        checkOutput({tag, "_txclear"}, {63'd0, txValid}, 64'd0);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(w[8*k +: 8]);
        end
    endtask

    task automatic sendImem(input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] csum);
        applyStimulus(8'h40);
        sendWord(addr);
        sendWord(data);
        applyStimulus(csum);
    endtask

    task automatic sendBmem(input logic [31:0] addr, input logic [7:0] csum);
        applyStimulus(8'h80);
        sendWord(addr);
        for (int n = 0; n < 64; n++) begin
            applyStimulus(8'(n));
        end
        applyStimulus(csum);
    endtask

    initial begin
        int waited;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_txvalid", {63'd0, txValid}, 64'd0);
        checkOutput("rst_txdata", {56'd0, txData}, 64'd0);
        checkOutput("rst_rxready", {63'd0, rxReady}, 64'd1);
        checkOutput("rst_running", {61'd0, threadRunning}, 64'd0);
        checkOutput("rst_imemvalid", {61'd0, imemValid}, 64'd0);
        checkOutput("rst_bmemvalid", {63'd0, bmemValid}, 64'd0);
        reset = 1'b0;
        tick();

        // PING and back-pressure while the reply is held.
        $display("[TB] ping");
        applyStimulus(8'h00);
        checkOutput("ping_rxready0", {63'd0, rxReady}, 64'd0);
        tick();
        tick();
        checkOutput("ping_hold_valid", {63'd0, txValid}, 64'd1);
        checkOutput("ping_hold_rxready", {63'd0, rxReady}, 64'd0);
        takeResponse("ping", 8'hA5);
        checkOutput("ping_rxready1", {63'd0, rxReady}, 64'd1);

        // IMEM frame with all threads idle goes to thread 0.
        $display("[TB] imem to thread 0");
        sendImem(32'h0000_0010, 32'hDEAD_BEEF, 8'h32);
        checkOutput("imem0_strobe", {61'd0, imemValid}, 64'h1);
        checkOutput("imem0_addr", {32'd0, imemAddr}, 64'h10);
        checkOutput("imem0_data", {32'd0, imemData}, 64'hDEAD_BEEF);
        takeResponse("imem0", 8'h06);
        checkOutput("imem0_single", {61'd0, imemValid}, 64'd0);

        // Threads 0 and 1 running: write lands on thread 2.
        $display("[TB] update and imem to thread 2");
        applyStimulus(8'hC3);
        checkOutput("upd3_running", {61'd0, threadRunning}, 64'h3);
        takeResponse("upd3", 8'h06);
        sendImem(32'h0000_0010, 32'hDEAD_BEEF, 8'h32);
        checkOutput("imem2_strobe", {61'd0, imemValid}, 64'h4);
        takeResponse("imem2", 8'h06);

        // All threads running: busy, no strobe.
        applyStimulus(8'hC7);
        checkOutput("upd7_running", {61'd0, threadRunning}, 64'h7);
        takeResponse("upd7", 8'h06);
        sendImem(32'h0000_0010, 32'hDEAD_BEEF, 8'h32);
        checkOutput("busy_strobe", {61'd0, imemValid}, 64'd0);
        takeResponse("busy", 8'h16);

        // BMEM tile 0x00..0x3F at 0x100: checksum = 0x01 (data bytes cancel).
        $display("[TB] bmem tile");
        sendBmem(32'h0000_0100, 8'h01);
        checkOutput("bmem_strobe", {63'd0, bmemValid}, 64'd1);
        checkOutput("bmem_addr", {32'd0, bmemAddr}, 64'h100);
        checkOutput("bmem_word0", {32'd0, bmemData[0 +: 32]}, 64'h0302_0100);
        checkOutput("bmem_word15", {32'd0, bmemData[15*32 +: 32]}, 64'h3F3E_3D3C);
        checkOutput("bmem_imem_quiet", {61'd0, imemValid}, 64'd0);
        takeResponse("bmem", 8'h06);
        checkOutput("bmem_single", {63'd0, bmemValid}, 64'd0);

        // Same tile with a corrupted checksum.
        sendBmem(32'h0000_0100, 8'hFE);
        checkOutput("nack_strobe", {63'd0, bmemValid}, 64'd0);
        takeResponse("nack", 8'h15);

        // Stall after three address bytes.
        $display("[TB] timeout");
        applyStimulus(8'h80);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        waited = 0;
        while (txValid !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        checkOutput("timeout_cycles", 64'(waited), 64'd100);
        checkOutput("timeout_bmem", {63'd0, bmemValid}, 64'd0);
        takeResponse("timeout", 8'h17);
        applyStimulus(8'h00);
        takeResponse("after_timeout_ping", 8'hA5);

        // Reset in the middle of the data bytes.
        $display("[TB] reset mid-frame");
        applyStimulus(8'h40);
        sendWord(32'h0000_0020);
        applyStimulus(8'h78);
        applyStimulus(8'h56);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_txvalid", {63'd0, txValid}, 64'd0);
        checkOutput("mid_rst_running", {61'd0, threadRunning}, 64'd0);
        checkOutput("mid_rst_imem", {61'd0, imemValid}, 64'd0);
        checkOutput("mid_rst_bmem", {63'd0, bmemValid}, 64'd0);
        checkOutput("mid_rst_rxready", {63'd0, rxReady}, 64'd1);
        sendImem(32'h0000_0020, 32'h1234_5678, 8'h28);
        checkOutput("post_rst_strobe", {61'd0, imemValid}, 64'h1);
        checkOutput("post_rst_addr", {32'd0, imemAddr}, 64'h20);
        checkOutput("post_rst_data", {32'd0, imemData}, 64'h1234_5678);
        takeResponse("post_rst", 8'h06);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
